// File: rtl/bla_sub16_pipe.sv
// bla_sub16_pipe: 16-bit subtractor, four 4-bit borrow-lookahead stages with valid/ready flow control.
// Optional BLA_SUB_OVF_EN adds the signed-overflow output ovf, aligned with d.
module bla_sub16_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        bIn,
    output logic        outValid,
    input  logic        outReady,
    output logic [15:0] d,
    output logic        bOut
`ifdef BLA_SUB_OVF_EN
    ,
    output logic        ovf
`endif
);

    function automatic logic [4:0] nib(input logic [3:0] a, input logic [3:0] s, input logic c);
        logic [3:0] g, p;
        logic [4:0] w;
        g = ~a & s;
        p = ~(a ^ s);
        w[0] = c;
        w[1] = g[0] | (p[0] & c);
        w[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        w[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        w[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c);
        return {w[4], a ^ s ^ w[3:0]};
    endfunction

    logic        v0, v1, v2;
    logic        b0, b1, b2;
    logic [3:0]  d0;
    logic [7:0]  d1;
    logic [11:0] d2;
    logic [11:0] x0, y0;
    logic [7:0]  x1, y1;
    logic [3:0]  x2, y2;
    logic [3:0]  adv;
    logic [4:0]  n0, n1, n2, n3;

    // stall chain from the output back to the input, plus the per-nibble borrow lookahead
    always_comb begin
        adv[3]  = ~outValid | outReady;
        adv[2]  = ~v2 | adv[3];
        adv[1]  = ~v1 | adv[2];
        adv[0]  = ~v0 | adv[1];
        inReady = adv[0];
        n0 = nib(x[3:0], y[3:0], bIn);
        n1 = nib(x0[3:0], y0[3:0], b0);
        n2 = nib(x1[3:0], y1[3:0], b1);
        n3 = nib(x2, y2, b2);
    end

    // stage 0: resolve nibble 0, forward the upper 12 operand bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            b0 <= 1'b0;
            d0 <= '0;
            x0 <= '0;
            y0 <= '0;
        end else if (adv[0]) begin
            v0 <= inValid;
            if (inValid) begin
                {b0, d0} <= n0;
                x0 <= x[15:4];
                y0 <= y[15:4];
            end
        end
    end

    // stage 1: resolve nibble 1, forward the upper 8 operand bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            b1 <= 1'b0;
            d1 <= '0;
            x1 <= '0;
            y1 <= '0;
        end else if (adv[1]) begin
            v1 <= v0;
            if (v0) begin
                {b1, d1[7:4]} <= n1;
                d1[3:0] <= d0;
                x1 <= x0[11:4];
                y1 <= y0[11:4];
            end
        end
    end

    // stage 2: resolve nibble 2, forward the top nibble (which carries the sign bits)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            b2 <= 1'b0;
            d2 <= '0;
            x2 <= '0;
            y2 <= '0;
        end else if (adv[2]) begin
            v2 <= v1;
            if (v1) begin
                {b2, d2[11:8]} <= n2;
                d2[7:0] <= d1;
                x2 <= x1[7:4];
                y2 <= y1[7:4];
            end
        end
    end

    // stage 3: resolve nibble 3 into the output registers, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid <= 1'b0;
            bOut     <= 1'b0;
            d        <= '0;
`ifdef BLA_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (adv[3]) begin
            outValid <= v2;
            if (v2) begin
                {bOut, d[15:12]} <= n3;
                d[11:0] <= d2;
`ifdef BLA_SUB_OVF_EN
                ovf <= (x2[3] ^ y2[3]) & (n3[3] ^ x2[3]);
`endif
            end
        end
    end

endmodule
